// File: rtl/prog_loader_pkg.sv
// Shared types and default constants for the program loader and its run timer.
package prog_loader_pkg;

   localparam int unsigned IW_DEF       = 9;
   localparam int unsigned AW_DEF       = 12;
   localparam int unsigned CW_DEF       = 16;
   localparam int unsigned RST_HOLD_DEF = 2;
   localparam int unsigned TIMEOUT_DEF  = 60000;

   typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE, TOUT} ldr_state_t;

endpackage

// File: rtl/prog_loader_run_timer.sv
// Run-cycle counter with synchronous clear/enable and a terminal-count flag at TIMEOUT.
module run_timer
   import prog_loader_pkg::*;
#(
   parameter int unsigned CW      = CW_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [CW-1:0] count_o,
   output logic          tc_o
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/prog_loader.sv
// Loads a program into instruction memory with the core held in reset, then runs it
// until core_done or timeout. Define PROG_LOADER_CHECKSUM_EN to enable the load_sum adder.
//
// Handshake: a word transfers on a rising edge where in_valid & in_ready are both high;
// in_ready is high only in LOAD and in_valid is ignored elsewhere.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned IW       = IW_DEF,
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned CW       = CW_DEF,
   parameter int unsigned RST_HOLD = RST_HOLD_DEF,
   parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] in_data,
   input  logic          in_last,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [IW-1:0] imem_wdata,
   output logic          core_reset,
   input  logic          core_done,
   output logic          busy,
   output logic          finished,
   output logic          timed_out,
   output logic          overflow,
   output logic [AW:0]   words_loaded,
   output logic [CW-1:0] cycle_count,
   output logic [15:0]   load_sum,
   output ldr_state_t    dbg_state
);

   ldr_state_t    state_q;
   logic [7:0]    hold_q;
   logic [AW:0]   words_q;
   logic          imem_we_q;
   logic [AW-1:0] imem_addr_q;
   logic [IW-1:0] imem_wdata_q;
   logic          finished_q;
   logic          timed_out_q;
   logic          overflow_q;

   logic          start_acc;
   logic          hs;
   logic          at_top;
   logic          hold_last;
   logic          tmr_en;
   logic          tmr_tc;

   assign start_acc = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == TOUT));
   assign hs        = in_valid & (state_q == LOAD);
   assign at_top    = (words_q[AW-1:0] == {AW{1'b1}});
   assign hold_last = (state_q == HOLD) & (hold_q == 8'(RST_HOLD - 1));
   // The first RUN cycle already reads 1, so the count starts on the last HOLD edge.
   assign tmr_en    = hold_last | ((state_q == RUN) & ~core_done & ~tmr_tc);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         words_q      <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         finished_q   <= 1'b0;
         timed_out_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         imem_we_q <= 1'b0;
         case (state_q)
            IDLE, DONE, TOUT: begin
               if (start) begin
                  state_q     <= LOAD;
                  words_q     <= '0;
                  finished_q  <= 1'b0;
                  timed_out_q <= 1'b0;
                  overflow_q  <= 1'b0;
               end
            end
            LOAD: begin
               if (hs) begin
                  imem_we_q    <= 1'b1;
                  imem_addr_q  <= words_q[AW-1:0];
                  imem_wdata_q <= in_data;
                  words_q      <= words_q + 1'b1;
                  if (in_last || at_top) begin
                     state_q <= HOLD;
                     hold_q  <= '0;
                  end
                  if (at_top && !in_last) begin
                     overflow_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (hold_last) begin
                  state_q <= RUN;
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            RUN: begin
               if (core_done) begin
                  state_q    <= DONE;
                  finished_q <= 1'b1;
               end else if (tmr_tc) begin
                  state_q     <= TOUT;
                  timed_out_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   run_timer #(
      .CW      (CW),
      .TIMEOUT (TIMEOUT)
   ) u_run_timer (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (start_acc),
      .en_i    (tmr_en),
      .count_o (cycle_count),
      .tc_o    (tmr_tc)
   );

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [15:0] sum_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_q <= '0;
      end else if (start_acc) begin
         sum_q <= '0;
      end else if (hs) begin
         sum_q <= sum_q + 16'(in_data);
      end
   end

   assign load_sum = sum_q;
`else
   assign load_sum = 16'h0000;
`endif

   assign in_ready     = (state_q == LOAD);
   assign busy         = (state_q == LOAD) | (state_q == HOLD) | (state_q == RUN);
   assign core_reset   = (state_q != RUN);
   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign finished     = finished_q;
   assign timed_out    = timed_out_q;
   assign overflow     = overflow_q;
   assign words_loaded = words_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized program loads and runs checked
// against a behavioural model of load, hold, run and timeout outcomes.
module tb_prog_loader;
   import prog_loader_pkg::*;

   localparam int IW       = 9;
   localparam int AW       = 12;
   localparam int CW       = 16;
   localparam int RST_HOLD = 2;
   localparam int TMO      = 20;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_wdata;
   logic          core_reset;
   logic          core_done = 1'b0;
   logic          busy;
   logic          finished;
   logic          timed_out;
   logic          overflow;
   logic [AW:0]   words_loaded;
   logic [CW-1:0] cycle_count;
   logic [15:0]   load_sum;
   ldr_state_t    dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [AW+IW-1:0] exp_q[$];
   logic [IW-1:0]    prog[0:4095];
   int               exp_words;
   logic [15:0]      exp_sum;

   prog_loader #(
      .IW(IW), .AW(AW), .CW(CW), .RST_HOLD(RST_HOLD), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_reset(core_reset), .core_done(core_done), .busy(busy),
      .finished(finished), .timed_out(timed_out), .overflow(overflow),
      .words_loaded(words_loaded), .cycle_count(cycle_count), .load_sum(load_sum),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_load_sum(input logic [15:0] s);
`ifdef PROG_LOADER_CHECKSUM_EN
      return s;
`else
      return 16'h0000;
`endif
   endfunction

   // Pulse start from a negedge; returns at the negedge after the accepting edge.
   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_words = 0;
      exp_sum   = '0;
      check("start_state", 32'(dbg_state), 32'(LOAD));
      check("start_ready", 32'(in_ready), 32'd1);
      check("start_busy", 32'(busy), 32'd1);
      check("start_flags", {29'd0, finished, timed_out, overflow}, 32'd0);
      check("start_words", 32'(words_loaded), 32'd0);
      check("start_cycles", 32'(cycle_count), 32'd0);
      check("start_sum", 32'(load_sum), 32'd0);
   endtask

   // Stream n words of prog[]; in_last on the n-th when use_last is set.
   task automatic load_words(input int n, input bit use_last, input bit rand_valid);
      int  sent  = 0;
      int  guard = 0;
      bit  hs;
      logic [AW+IW-1:0] e;
      while (sent < n && guard < 20000) begin
         in_valid  = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data   = prog[sent];
         in_last   = use_last && (sent == n - 1);
         core_done = rand_valid ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         check("load_ready", 32'(in_ready), 32'd1);
         hs = in_valid;
         if (hs) begin
            exp_q.push_back({AW'(sent), prog[sent]});
            exp_sum = exp_sum + 16'(prog[sent]);
         end
         @(negedge clk);
         if (hs) begin
            e = exp_q.pop_front();
            check("imem_we", 32'(imem_we), 32'd1);
            check("imem_addr", 32'(imem_addr), 32'(e[AW+IW-1:IW]));
            check("imem_wdata", 32'(imem_wdata), 32'(e[IW-1:0]));
            sent++;
         end else begin
            check("imem_we_idle", 32'(imem_we), 32'd0);
         end
         guard++;
      end
      if (guard >= 20000) check("load_budget", 32'(sent), 32'(n));
      in_valid  = 1'b0;
      in_last   = 1'b0;
      core_done = 1'b0;
      exp_words = sent;
      check("words_loaded", 32'(words_loaded), 32'(exp_words));
      check("load_sum", 32'(load_sum), 32'(exp_load_sum(exp_sum)));
   endtask

   // Called right after the final load handshake; done_at=0 means core_done never rises.
   task automatic run_core(input int done_at);
      int hold = 0;
      int exp_cnt;
      bit exp_done;
      while (core_reset && hold < 50) begin
         check("hold_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
         hold++;
      end
      check("rst_hold", 32'(hold), 32'(RST_HOLD));
      exp_done = (done_at > 0) && (done_at <= TMO);
      exp_cnt  = exp_done ? done_at : TMO;
      for (int k = 1; k <= exp_cnt; k++) begin
         if (k == 1 || k == exp_cnt || k == 3) check("run_count", 32'(cycle_count), 32'(k));
         check("run_core_reset", 32'(core_reset), 32'd0);
         start     = (k == 3);
         core_done = (k == done_at);
         if (k < exp_cnt) @(negedge clk);
      end
      @(negedge clk);
      start     = 1'b0;
      core_done = 1'b0;
      check("end_finished", 32'(finished), 32'(exp_done));
      check("end_timed_out", 32'(timed_out), 32'(!exp_done));
      check("end_cycles", 32'(cycle_count), 32'(exp_cnt));
      check("end_core_reset", 32'(core_reset), 32'd1);
      check("end_busy", 32'(busy), 32'd0);
      core_done = 1'b1;
      repeat (3) @(negedge clk);
      core_done = 1'b0;
      check("hold_cycles", 32'(cycle_count), 32'(exp_cnt));
      check("hold_words", 32'(words_loaded), 32'(exp_words));
      check("hold_finished", 32'(finished), 32'(exp_done));
   endtask

   initial begin
      // Reset and idle
      repeat (3) @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b1;
      core_done = 1'b1;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      core_done = 1'b0;
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      check("rst_core_reset", 32'(core_reset), 32'd1);
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_flags", {28'd0, finished, timed_out, overflow, busy}, 32'd0);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_counts", 32'(words_loaded) | 32'(cycle_count) | 32'(load_sum), 32'd0);

      // Fixed four-word program, core finishes on run cycle 10
      prog[0] = 9'h101; prog[1] = 9'h0A2; prog[2] = 9'h1FF; prog[3] = 9'h003;
      do_start();
      load_words(4, 1'b1, 1'b0);
      run_core(10);

      // Random program, timeout, then restart with done and timeout coinciding
      for (int i = 0; i < 8; i++) prog[i] = IW'($urandom);
      do_start();
      load_words($urandom_range(1, 8), 1'b1, 1'b1);
      run_core(0);
      for (int i = 0; i < 8; i++) prog[i] = IW'($urandom);
      do_start();
      load_words(3, 1'b1, 1'b1);
      run_core(TMO);

      // Program fills the whole address space without in_last
      for (int i = 0; i < 4096; i++) prog[i] = IW'($urandom);
      do_start();
      load_words(4096, 1'b0, 1'b0);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_state", 32'(dbg_state), 32'(HOLD));
      check("ovf_ready", 32'(in_ready), 32'd0);
      run_core($urandom_range(4, 15));
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Reset dropped mid-load
      for (int i = 0; i < 4; i++) prog[i] = IW'($urandom);
      do_start();
      load_words(2, 1'b0, 1'b0);
      check("mid_state", 32'(dbg_state), 32'(LOAD));
      reset = 1'b0;
      #1;
      check("arst_state", 32'(dbg_state), 32'(IDLE));
      check("arst_we", 32'(imem_we), 32'd0);
      check("arst_core_reset", 32'(core_reset), 32'd1);
      check("arst_ready", 32'(in_ready), 32'd0);
      check("arst_words", 32'(words_loaded), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_state", 32'(dbg_state), 32'(IDLE));
      check("post_rst_sum", 32'(load_sum), 32'd0);
      check("leftover_writes", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
